// File: rtl/snake_map_writer.sv
`default_nettype none
// ============================================================================
// Module      : snake_map_writer
// Description : Maintains a 16x16 snake tile map in an external RAM. Clears the
//               map, draws the initial 3-segment snake, then turns accepted
//               steps and food requests into ordered single-cycle tile writes.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_map_writer #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_valid,
    input  logic [1:0] dir,
    input  logic       grow,
    output logic       step_ready,
    input  logic       food_valid,
    input  logic [3:0] food_x,
    input  logic [3:0] food_y,
    output logic       food_ready,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [3:0] ram_wdata,
    output logic       init_done,
    output logic       busy
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = AW + 1;
    localparam logic [1:0] DIR_RIGHT = 2'b01;

    typedef enum logic [3:0] {
        CLEAR, INIT_T, INIT_B, INIT_H, IDLE,
        W_OLDHEAD, W_NEWHEAD, W_CLRTAIL, W_NEWTAIL, W_FOOD
    } state_t;

    state_t        state;
    logic [7:0]    clr_cnt;
    logic [3:0]    head_x, head_y, new_x, new_y;
    logic [1:0]    head_dir, step_dir;
    logic          grow_q;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    // Segment queue: coordinates {y,x} and entry direction, oldest at rd_ptr
    logic [7:0]    seg_xy  [MAX_LEN];
    logic [1:0]    seg_dir [MAX_LEN];

    logic          push;
    logic [7:0]    push_xy;
    logic [1:0]    push_dir;
    logic [1:0]    eff_dir;
    logic [3:0]    nx, ny;
    logic [1:0]    h_side, v_side;
    logic [3:0]    body_code;

    // A reversal request is replaced by continuing straight; next head cell
    // uses 4-bit wraparound in both axes.
    always_comb begin
        eff_dir = (dir == {head_dir[1], ~head_dir[0]}) ? head_dir : dir;
        nx = head_x;
        ny = head_y;
        case (eff_dir)
            2'b00:   nx = head_x - 4'd1;
            2'b01:   nx = head_x + 4'd1;
            2'b10:   ny = head_y - 4'd1;
            default: ny = head_y + 4'd1;
        endcase
    end

    // Tile left behind at the old head: straight body or the corner joining
    // the side we came in from with the side we leave through.
    always_comb begin
        if (!head_dir[1]) begin
            h_side = {head_dir[1], ~head_dir[0]};
            v_side = eff_dir;
        end else begin
            h_side = eff_dir;
            v_side = {head_dir[1], ~head_dir[0]};
        end
        if (eff_dir == head_dir)
            body_code = head_dir[1] ? 4'h3 : 4'h2;
        else
            body_code = {2'b01, v_side[0], h_side[0]};
    end

    // Queue pushes happen when leaving each initial draw state and W_NEWHEAD
    always_comb begin
        push     = 1'b0;
        push_xy  = 8'h00;
        push_dir = DIR_RIGHT;
        case (state)
            INIT_T:    begin push = 1'b1; push_xy = 8'h86; end
            INIT_B:    begin push = 1'b1; push_xy = 8'h87; end
            INIT_H:    begin push = 1'b1; push_xy = 8'h88; end
            W_NEWHEAD: begin push = 1'b1; push_xy = {new_y, new_x}; push_dir = step_dir; end
            default:   ;
        endcase
    end

    // Segment storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            seg_xy[wr_ptr]  <= push_xy;
            seg_dir[wr_ptr] <= push_dir;
        end
    end

    // Main sequencer: the ram_* registers are loaded on the edge entering a
    // write state, so ram_we is high exactly while that state is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= 8'h00;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_x    <= 4'd8;
            head_y    <= 4'd8;
            head_dir  <= DIR_RIGHT;
            step_dir  <= DIR_RIGHT;
            grow_q    <= 1'b0;
            new_x     <= 4'd0;
            new_y     <= 4'd0;
            ram_we    <= 1'b0;
            ram_addr  <= 8'h00;
            ram_wdata <= 4'h0;
            init_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case (state)
                CLEAR: begin
                    if (ram_we && ram_addr == 8'hFF) begin
                        state     <= INIT_T;
                        ram_addr  <= 8'h86;
                        ram_wdata <= 4'h9;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_addr  <= clr_cnt;
                        ram_wdata <= 4'h0;
                        clr_cnt   <= clr_cnt + 8'd1;
                    end
                end
                INIT_T: begin
                    state     <= INIT_B;
                    ram_addr  <= 8'h87;
                    ram_wdata <= 4'h2;
                    count     <= count + CW'(1);
                end
                INIT_B: begin
                    state     <= INIT_H;
                    ram_addr  <= 8'h88;
                    ram_wdata <= 4'hD;
                    count     <= count + CW'(1);
                end
                INIT_H: begin
                    state     <= IDLE;
                    ram_we    <= 1'b0;
                    init_done <= 1'b1;
                    count     <= count + CW'(1);
                    head_x    <= 4'd8;
                    head_y    <= 4'd8;
                    head_dir  <= DIR_RIGHT;
                end
                IDLE: begin
                    if (step_valid) begin
                        state     <= W_OLDHEAD;
                        ram_we    <= 1'b1;
                        ram_addr  <= {head_y, head_x};
                        ram_wdata <= body_code;
                        step_dir  <= eff_dir;
                        grow_q    <= grow;
                        new_x     <= nx;
                        new_y     <= ny;
                    end else if (food_valid) begin
                        state     <= W_FOOD;
                        ram_we    <= 1'b1;
                        ram_addr  <= {food_y, food_x};
                        ram_wdata <= 4'h1;
                    end else begin
                        ram_we    <= 1'b0;
                    end
                end
                W_OLDHEAD: begin
                    state     <= W_NEWHEAD;
                    ram_addr  <= {new_y, new_x};
                    ram_wdata <= {2'b11, step_dir};
                end
                W_NEWHEAD: begin
                    head_x   <= new_x;
                    head_y   <= new_y;
                    head_dir <= step_dir;
                    count    <= count + CW'(1);
                    if (!grow_q || count == CW'(MAX_LEN)) begin
                        // Old tail is read before this edge's push can land on it
                        state     <= W_CLRTAIL;
                        ram_addr  <= seg_xy[rd_ptr];
                        ram_wdata <= 4'h0;
                    end else begin
                        state  <= IDLE;
                        ram_we <= 1'b0;
                    end
                end
                W_CLRTAIL: begin
                    state     <= W_NEWTAIL;
                    rd_ptr    <= rd_ptr + AW'(1);
                    count     <= count - CW'(1);
                    ram_addr  <= seg_xy[rd_ptr + AW'(1)];
                    ram_wdata <= {2'b10, seg_dir[rd_ptr + AW'(2)]};
                end
                W_NEWTAIL, W_FOOD: begin
                    state  <= IDLE;
                    ram_we <= 1'b0;
                end
                default: begin
                    state  <= CLEAR;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

    assign step_ready = (state == IDLE);
    assign food_ready = (state == IDLE) && !step_valid;
    assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snake_map_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_map_writer
// Description : Directed self-checking bench for snake_map_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_map_writer;
    logic       clk = 1'b0;
    logic       rst;
    logic       step_valid, grow, step_ready;
    logic [1:0] dir;
    logic       food_valid, food_ready;
    logic [3:0] food_x, food_y;
    logic       ram_we, init_done, busy;
    logic [7:0] ram_addr;
    logic [3:0] ram_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] wa [8];
    logic [3:0] wd [8];

    snake_map_writer #(.MAX_LEN(64)) dut (
        .clk(clk), .rst(rst),
        .step_valid(step_valid), .dir(dir), .grow(grow), .step_ready(step_ready),
        .food_valid(food_valid), .food_x(food_x), .food_y(food_y), .food_ready(food_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one step and record the writes and cycles until step_ready returns
    task automatic run_step(input logic [1:0] d, input logic g, output int nw, output int lat);
        nw = 0;
        lat = 0;
        @(negedge clk);
        step_valid = 1'b1;
        dir = d;
        grow = g;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        dir = ~d;
        grow = ~g;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ram_we && nw < 8) begin
                wa[nw] = ram_addr;
                wd[nw] = ram_wdata;
                nw++;
            end
            if (step_ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({ram_we, ram_addr, ram_wdata, init_done, step_ready, food_ready, busy} !== 17'h00001) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h done=%b sr=%b fr=%b busy=%b, required 0/00/0/0/0/0/1",
                     ram_we, ram_addr, ram_wdata, init_done, step_ready, food_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clear_init;
        int bad_i;
        logic [7:0] ea [3];
        logic [3:0] ed [3];
        ea[0] = 8'h86; ed[0] = 4'h9;
        ea[1] = 8'h87; ed[1] = 4'h2;
        ea[2] = 8'h88; ed[2] = 4'hD;
        bad_i = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ram_we) break;
        end
        for (int i = 0; i < 256; i++) begin
            if (bad_i < 0 && !(ram_we === 1'b1 && ram_addr === 8'(i) && ram_wdata === 4'h0 && init_done === 1'b0))
                bad_i = i;
            if (i < 255) @(negedge clk);
        end
        n_cmp++;
        if (bad_i >= 0) begin
            n_bad++;
            $display("FAIL clear_seq: at index %0d got we=%b addr=%h data=%h done=%b, required 1/%h/0/0",
                     bad_i, ram_we, ram_addr, ram_wdata, init_done, 8'(bad_i));
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if (ram_we !== 1'b1 || ram_addr !== ea[j] || ram_wdata !== ed[j]) begin
                n_bad++;
                $display("FAIL init_write%0d: got we=%b addr=%h data=%h, required 1/%h/%h",
                         j, ram_we, ram_addr, ram_wdata, ea[j], ed[j]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({ram_we, init_done, step_ready, busy} !== 4'b0110) begin
            n_bad++;
            $display("FAIL init_done_state: we/done/sr/busy=%b, required 0110", {ram_we, init_done, step_ready, busy});
        end
    endtask

    task automatic test_step_straight;
        int nw, lat;
        run_step(2'b01, 1'b0, nw, lat);
        n_cmp++;
        if (nw !== 4 || wa[0] !== 8'h88 || wd[0] !== 4'h2 || wa[1] !== 8'h89 || wd[1] !== 4'hD ||
            wa[2] !== 8'h86 || wd[2] !== 4'h0 || wa[3] !== 8'h87 || wd[3] !== 4'h9) begin
            n_bad++;
            $display("FAIL step_straight_writes: n=%0d %h=%h %h=%h %h=%h %h=%h, required 4 88=2 89=D 86=0 87=9",
                     nw, wa[0], wd[0], wa[1], wd[1], wa[2], wd[2], wa[3], wd[3]);
        end
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL step_straight_latency: got %0d, required 5", lat);
        end
    endtask

    task automatic test_reset_mid_step;
        @(negedge clk);
        step_valid = 1'b1; dir = 2'b01; grow = 1'b0;
        @(posedge clk);
        #1 step_valid = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 8'h8A || ram_wdata !== 4'hD) begin
            n_bad++;
            $display("FAIL newhead_before_reset: we=%b addr=%h data=%h, required 1/8a/d", ram_we, ram_addr, ram_wdata);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_we, ram_addr, init_done, step_ready, busy} !== 12'h001) begin
            n_bad++;
            $display("FAIL midstep_reset: we=%b addr=%h done=%b sr=%b busy=%b, required 0/00/0/0/1",
                     ram_we, ram_addr, init_done, step_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_step_grow_up;
        int nw, lat;
        run_step(2'b10, 1'b1, nw, lat);
        n_cmp++;
        if (nw !== 2 || wa[0] !== 8'h88 || wd[0] !== 4'h4 || wa[1] !== 8'h78 || wd[1] !== 4'hE) begin
            n_bad++;
            $display("FAIL grow_up_writes: n=%0d %h=%h %h=%h, required 2 88=4 78=E", nw, wa[0], wd[0], wa[1], wd[1]);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL grow_up_latency: got %0d, required 3", lat);
        end
    endtask

    task automatic test_opposite_dir;
        int nw, lat;
        // heading up at (8,7); a down request keeps going up
        run_step(2'b11, 1'b0, nw, lat);
        n_cmp++;
        if (nw !== 4 || wa[0] !== 8'h78 || wd[0] !== 4'h3 || wa[1] !== 8'h68 || wd[1] !== 4'hE ||
            wa[2] !== 8'h86 || wd[2] !== 4'h0 || wa[3] !== 8'h87 || wd[3] !== 4'h9) begin
            n_bad++;
            $display("FAIL opposite_writes: n=%0d %h=%h %h=%h %h=%h %h=%h, required 4 78=3 68=E 86=0 87=9",
                     nw, wa[0], wd[0], wa[1], wd[1], wa[2], wd[2], wa[3], wd[3]);
        end
    endtask

    task automatic test_wrap;
        int nw, lat;
        // up at (8,6) turning right: right-down corner
        run_step(2'b01, 1'b1, nw, lat);
        n_cmp++;
        if (nw !== 2 || wa[0] !== 8'h68 || wd[0] !== 4'h7 || wa[1] !== 8'h69 || wd[1] !== 4'hD) begin
            n_bad++;
            $display("FAIL corner_right_down: n=%0d %h=%h %h=%h, required 2 68=7 69=D", nw, wa[0], wd[0], wa[1], wd[1]);
        end
        for (int s = 0; s < 6; s++) run_step(2'b01, 1'b1, nw, lat);
        n_cmp++;
        if (wa[1] !== 8'h6F || wd[1] !== 4'hD) begin
            n_bad++;
            $display("FAIL reach_x15: head write %h=%h, required 6f=D", wa[1], wd[1]);
        end
        // left request while heading right at x=15: continues right and wraps
        run_step(2'b00, 1'b1, nw, lat);
        n_cmp++;
        if (nw !== 2 || wa[0] !== 8'h6F || wd[0] !== 4'h2 || wa[1] !== 8'h60 || wd[1] !== 4'hD) begin
            n_bad++;
            $display("FAIL wrap_right: n=%0d %h=%h %h=%h, required 2 6f=2 60=D", nw, wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_step_food_priority;
        int nw;
        nw = 0;
        @(negedge clk);
        step_valid = 1'b1; dir = 2'b01; grow = 1'b1;
        food_valid = 1'b1; food_x = 4'd3; food_y = 4'd5;
        #1;
        n_cmp++;
        if (food_ready !== 1'b0 || step_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL priority_ready: food_ready=%b step_ready=%b, required 0/1", food_ready, step_ready);
        end
        @(posedge clk);
        #1 step_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ram_we && nw < 8) begin
                wa[nw] = ram_addr;
                wd[nw] = ram_wdata;
                nw++;
            end
            if (food_ready && food_valid) begin
                @(posedge clk);
                #1 food_valid = 1'b0;
            end
        end
        n_cmp++;
        if (nw !== 3 || wa[0] !== 8'h60 || wd[0] !== 4'h2 || wa[1] !== 8'h61 || wd[1] !== 4'hD ||
            wa[2] !== 8'h53 || wd[2] !== 4'h1) begin
            n_bad++;
            $display("FAIL step_then_food: n=%0d %h=%h %h=%h %h=%h, required 3 60=2 61=D 53=1",
                     nw, wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
        end
        food_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step_valid = 1'b0; dir = 2'b00; grow = 1'b0;
        food_valid = 1'b0; food_x = 4'd0; food_y = 4'd0;
        test_reset();
        test_clear_init();
        test_step_straight();
        test_reset_mid_step();
        test_clear_init();
        test_step_grow_up();
        test_opposite_dir();
        test_wrap();
        test_step_food_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
